// File: rtl/uart_reg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : uart_reg_ctrl_pkg
//  Brief   : Command/reply byte codes and FSM state encoding shared by the
//            UART register-access command sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
package uart_reg_ctrl_pkg;

   // Command bytes accepted as the first byte of a command
   localparam logic [7:0] CMD_W   = 8'h57;  // 'W'
   localparam logic [7:0] CMD_R   = 8'h52;  // 'R'

   // Reply bytes
   localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
   localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_GET_ADDR = 4'd1,
      ST_GET_DATA = 4'd2,
      ST_WR_ISSUE = 4'd3,
      ST_RD_ISSUE = 4'd4,
      ST_RD_CAPT  = 4'd5,
      ST_SEND     = 4'd6,
      ST_TX_START = 4'd7,
      ST_TX_DONE  = 4'd8
   } state_t;

   // True for the two command bytes that start a valid command
   function automatic logic is_cmd(input logic [7:0] b);
      return (b == CMD_W) || (b == CMD_R);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_reg_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : uart_reg_ctrl_if
//  Brief   : UART byte stream plus single-cycle register bus seen by the
//            command sequencer. master = sequencer, slave = UART/regfile side.
//  Rev     : 1.0  initial release
// ============================================================================
interface uart_reg_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        data_rx;
   logic              recieved;
   logic              busy_tx;
   logic              transmit;
   logic [7:0]        data_tx;
   logic [ADDR_W-1:0] reg_addr;
   logic [7:0]        reg_wdata;
   logic              reg_we;
   logic              reg_re;
   logic [7:0]        reg_rdata;

   modport master (
      input  data_rx, recieved, busy_tx, reg_rdata,
      output transmit, data_tx, reg_addr, reg_wdata, reg_we, reg_re
   );

   modport slave (
      output data_rx, recieved, busy_tx, reg_rdata,
      input  transmit, data_tx, reg_addr, reg_wdata, reg_we, reg_re
   );
endinterface
`default_nettype wire

// File: rtl/uart_byte_timeout.sv
`default_nettype none
// ============================================================================
//  Module  : uart_byte_timeout
//  Brief   : Inter-byte timeout. Down-counter reloaded on every received byte;
//            expire is raised while active once TIMEOUT-1 idle clocks elapsed.
//  Rev     : 1.0  initial release
// ============================================================================
module uart_byte_timeout #(
   parameter int TIMEOUT = 5000000
) (
   input  logic clk,
   input  logic nRst,
   input  logic clear,    // byte received: restart the interval
   input  logic active,   // sequencer is waiting for a command byte
   output logic expire
);
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   // Reload on a byte, otherwise count down and park at zero
   always_ff @(posedge clk) begin
      if (!nRst)
         count <= '0;
      else if (clear)
         count <= LOAD;
      else if (count != '0)
         count <= count - 1'b1;
   end

   // A byte arriving on the expiry cycle wins over the timeout
   assign expire = active && !clear && (count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : uart_reg_ctrl
//  Brief   : Parses 'W' addr data / 'R' addr byte commands from the UART,
//            issues single-cycle register accesses and sends a one-byte reply.
//  Rev     : 1.0  initial release
// ============================================================================
module uart_reg_ctrl
   import uart_reg_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 5000000
) (
   input  logic            clk,
   input  logic            nRst,
   uart_reg_ctrl_if.master bus,
   output logic            err
);
   state_t state, state_nxt;
   logic   is_wr;       // command in progress is a write
   logic   tmo_active;
   logic   tmo_expire;
   logic   drop;        // byte arrived while not parsing

   uart_byte_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk    (clk),
      .nRst   (nRst),
      .clear  (bus.recieved),
      .active (tmo_active),
      .expire (tmo_expire)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!nRst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode and single-cycle strobes; strobes are masked in reset
   always_comb begin
      state_nxt    = state;
      bus.reg_we   = 1'b0;
      bus.reg_re   = 1'b0;
      bus.transmit = 1'b0;
      tmo_active   = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
      drop         = bus.recieved && (state != ST_IDLE) && !tmo_active;
      case (state)
         ST_IDLE:
            if (bus.recieved)
               state_nxt = is_cmd(bus.data_rx) ? ST_GET_ADDR : ST_SEND;
         ST_GET_ADDR:
            if (bus.recieved)
               state_nxt = is_wr ? ST_GET_DATA : ST_RD_ISSUE;
            else if (tmo_expire)
               state_nxt = ST_IDLE;
         ST_GET_DATA:
            if (bus.recieved)
               state_nxt = ST_WR_ISSUE;
            else if (tmo_expire)
               state_nxt = ST_IDLE;
         ST_WR_ISSUE: begin
            bus.reg_we = nRst;
            state_nxt  = ST_SEND;
         end
         ST_RD_ISSUE: begin
            bus.reg_re = nRst;
            state_nxt  = ST_RD_CAPT;
         end
         ST_RD_CAPT:
            state_nxt = ST_SEND;
         ST_SEND:
            if (!bus.busy_tx) begin
               bus.transmit = nRst;
               state_nxt    = ST_TX_START;
            end
         ST_TX_START:
            if (bus.busy_tx)
               state_nxt = ST_TX_DONE;
         ST_TX_DONE:
            if (!bus.busy_tx)
               state_nxt = ST_IDLE;
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   // Command datapath: latch address/data/reply and the sticky error flag
   always_ff @(posedge clk) begin
      if (!nRst) begin
         is_wr         <= 1'b0;
         bus.data_tx   <= '0;
         bus.reg_addr  <= '0;
         bus.reg_wdata <= '0;
         err           <= 1'b0;
      end else begin
         case (state)
            ST_IDLE:
               if (bus.recieved) begin
                  is_wr <= (bus.data_rx == CMD_W);
                  if (!is_cmd(bus.data_rx)) begin
                     bus.data_tx <= RSP_ERR;
                     err         <= 1'b1;
                  end
               end
            ST_GET_ADDR:
               if (bus.recieved)
                  bus.reg_addr <= bus.data_rx[ADDR_W-1:0];
               else if (tmo_expire)
                  err <= 1'b1;
            ST_GET_DATA:
               if (bus.recieved)
                  bus.reg_wdata <= bus.data_rx;
               else if (tmo_expire)
                  err <= 1'b1;
            ST_WR_ISSUE: bus.data_tx <= RSP_OK;
            ST_RD_CAPT:  bus.data_tx <= bus.reg_rdata;
            default: ;
         endcase
         if (drop)
            err <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_uart_reg_ctrl
//  Brief   : Directed self-checking bench for uart_reg_ctrl: a table of
//            complete commands plus hand sequences for timeout, busy
//            transmitter and mid-command reset.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_uart_reg_ctrl;
   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic nRst = 1'b0;
   logic err;

   uart_reg_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   uart_reg_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus),
      .err  (err)
   );

   always #5 clk = ~clk;

   // Event log and UART/register models
   int         cyc = 0;
   int         rx_cyc = 0, we_cyc = 0, re_cyc = 0, tx_cyc = 0;
   int         we_cnt = 0, re_cnt = 0, tx_cnt = 0, tx_viol = 0;
   logic [7:0] we_addr = '0, we_data = '0, tx_last = '0;
   logic [7:0] rd_val = '0;
   logic       hold_busy = 1'b0;
   int         bcnt = 0;

   // Sample pre-edge values: record strobes, emulate UART busy and regfile read
   always @(posedge clk) begin
      cyc++;
      if (bus.recieved) rx_cyc = cyc;
      if (bus.reg_we) begin
         we_cnt++; we_cyc = cyc; we_addr = bus.reg_addr; we_data = bus.reg_wdata;
      end
      if (bus.reg_re) begin
         re_cnt++; re_cyc = cyc;
      end
      if (bus.transmit) begin
         tx_cnt++; tx_cyc = cyc; tx_last = bus.data_tx;
         if (bus.busy_tx) tx_viol++;
         bcnt = 4;
      end else if (bcnt != 0) begin
         bcnt--;
      end
      bus.busy_tx   <= hold_busy || (bcnt != 0);
      bus.reg_rdata <= bus.reg_re ? rd_val : 8'hEE;
   end

   int n_chk = 0, n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.data_rx  = b;
      bus.recieved = 1'b1;
      tick();
      bus.recieved = 1'b0;
   endtask

   task automatic do_reset();
      nRst = 1'b0;
      repeat (3) tick();
      nRst = 1'b1;
      tick();
   endtask

   typedef struct {
      logic [7:0] b0, b1, b2;
      int         nb;
      logic [7:0] rdata;
      int         we, re;
      logic [7:0] addr, wdata, txd;
      logic       err;
   } vec_t;

   localparam int NV = 7;
   vec_t v [NV];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int we0, re0, tx0;

      v[0] = '{8'h57, 8'h05, 8'hA5, 3, 8'h00, 1, 0, 8'h05, 8'hA5, 8'h4B, 1'b0};
      v[1] = '{8'h52, 8'h05, 8'h00, 2, 8'h3C, 0, 1, 8'h05, 8'hA5, 8'h3C, 1'b0};
      v[2] = '{8'h57, 8'h7F, 8'h00, 3, 8'h00, 1, 0, 8'h7F, 8'h00, 8'h4B, 1'b0};
      v[3] = '{8'h52, 8'h80, 8'h00, 2, 8'hC3, 0, 1, 8'h80, 8'h00, 8'hC3, 1'b0};
      v[4] = '{8'h57, 8'hFF, 8'h5A, 3, 8'h00, 1, 0, 8'hFF, 8'h5A, 8'h4B, 1'b0};
      v[5] = '{8'h00, 8'h00, 8'h00, 1, 8'h00, 0, 0, 8'hFF, 8'h5A, 8'h3F, 1'b1};
      v[6] = '{8'h72, 8'h00, 8'h00, 1, 8'h00, 0, 0, 8'hFF, 8'h5A, 8'h3F, 1'b1};

      bus.data_rx  = '0;
      bus.recieved = 1'b0;

      // Reset values
      nRst = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_transmit", bus.transmit, 0);
      chk("rst_we",       bus.reg_we, 0);
      chk("rst_re",       bus.reg_re, 0);
      chk("rst_err",      err, 0);
      chk("rst_data_tx",  bus.data_tx, 0);
      chk("rst_addr",     bus.reg_addr, 0);
      chk("rst_wdata",    bus.reg_wdata, 0);
      nRst = 1'b1;
      tick();

      // Table of complete commands
      for (int i = 0; i < NV; i++) begin
         rd_val = v[i].rdata;
         we0 = we_cnt; re0 = re_cnt; tx0 = tx_cnt;
         send_byte(v[i].b0);
         if (v[i].nb > 1) send_byte(v[i].b1);
         if (v[i].nb > 2) send_byte(v[i].b2);
         repeat (15) tick();
         @(negedge clk);
         chk($sformatf("v%0d_we_cnt", i), we_cnt - we0, v[i].we);
         chk($sformatf("v%0d_re_cnt", i), re_cnt - re0, v[i].re);
         chk($sformatf("v%0d_tx_cnt", i), tx_cnt - tx0, 1);
         chk($sformatf("v%0d_tx_data", i), tx_last, v[i].txd);
         chk($sformatf("v%0d_addr", i), bus.reg_addr, v[i].addr);
         chk($sformatf("v%0d_wdata", i), bus.reg_wdata, v[i].wdata);
         chk($sformatf("v%0d_err", i), err, v[i].err);
         if (v[i].we != 0) begin
            chk($sformatf("v%0d_we_addr", i), we_addr, v[i].addr);
            chk($sformatf("v%0d_we_data", i), we_data, v[i].wdata);
            chk($sformatf("v%0d_we_lat", i), we_cyc - rx_cyc, 1);
            chk($sformatf("v%0d_tx_lat", i), tx_cyc - rx_cyc, 2);
         end
         if (v[i].re != 0) begin
            chk($sformatf("v%0d_re_lat", i), re_cyc - rx_cyc, 1);
            chk($sformatf("v%0d_tx_lat", i), tx_cyc - rx_cyc, 3);
         end
      end

      // Bytes landing exactly on the expiry cycle keep the command alive
      do_reset();
      we0 = we_cnt; tx0 = tx_cnt;
      send_byte(8'h57);
      repeat (TIMEOUT - 1) tick();
      send_byte(8'h05);
      repeat (TIMEOUT - 1) tick();
      send_byte(8'hA5);
      repeat (15) tick();
      @(negedge clk);
      chk("edge_we_cnt", we_cnt - we0, 1);
      chk("edge_we_addr", we_addr, 8'h05);
      chk("edge_we_data", we_data, 8'hA5);
      chk("edge_tx", tx_last, 8'h4B);
      chk("edge_err", err, 0);

      // A full TIMEOUT of silence aborts the command without access or reply
      we0 = we_cnt; re0 = re_cnt; tx0 = tx_cnt;
      send_byte(8'h57);
      send_byte(8'h05);
      repeat (TIMEOUT) tick();
      @(negedge clk);
      chk("tmo_err", err, 1);
      chk("tmo_we_cnt", we_cnt - we0, 0);
      chk("tmo_tx_cnt", tx_cnt - tx0, 0);
      rd_val = 8'h3C;
      send_byte(8'h52);
      send_byte(8'h05);
      repeat (15) tick();
      @(negedge clk);
      chk("tmo_after_we", we_cnt - we0, 0);
      chk("tmo_after_re", re_cnt - re0, 1);
      chk("tmo_after_tx", tx_cnt - tx0, 1);
      chk("tmo_after_data", tx_last, 8'h3C);

      // Busy transmitter delays the reply; a byte during the wait is dropped
      do_reset();
      hold_busy = 1'b1;
      tick();
      we0 = we_cnt; tx0 = tx_cnt;
      send_byte(8'h57);
      send_byte(8'h01);
      send_byte(8'h22);
      repeat (10) tick();
      @(negedge clk);
      chk("busy_tx_held", tx_cnt - tx0, 0);
      chk("busy_we_cnt", we_cnt - we0, 1);
      chk("busy_err_pre", err, 0);
      send_byte(8'h57);
      repeat (3) tick();
      @(negedge clk);
      chk("busy_drop_err", err, 1);
      hold_busy = 1'b0;
      repeat (15) tick();
      @(negedge clk);
      chk("busy_tx_cnt", tx_cnt - tx0, 1);
      chk("busy_tx_data", tx_last, 8'h4B);
      chk("busy_we_after", we_cnt - we0, 1);
      chk("busy_tx_viol", tx_viol, 0);

      // Reset in the middle of a write discards it; next read is clean
      do_reset();
      we0 = we_cnt; re0 = re_cnt; tx0 = tx_cnt;
      send_byte(8'h57);
      send_byte(8'h03);
      nRst = 1'b0;
      tick();
      @(negedge clk);
      chk("mid_rst_transmit", bus.transmit, 0);
      chk("mid_rst_we", bus.reg_we, 0);
      chk("mid_rst_re", bus.reg_re, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_data_tx", bus.data_tx, 0);
      chk("mid_rst_addr", bus.reg_addr, 0);
      chk("mid_rst_wdata", bus.reg_wdata, 0);
      tick();
      nRst = 1'b1;
      tick();
      rd_val = 8'h99;
      send_byte(8'h52);
      send_byte(8'h01);
      repeat (15) tick();
      @(negedge clk);
      chk("post_rst_we", we_cnt - we0, 0);
      chk("post_rst_re", re_cnt - re0, 1);
      chk("post_rst_tx", tx_cnt - tx0, 1);
      chk("post_rst_data", tx_last, 8'h99);
      chk("post_rst_addr", bus.reg_addr, 8'h01);
      chk("post_rst_err", err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
